// File: rtl/seq_pkg.sv
// Shared types for the multicycle control sequencer: state encoding doubles as the
// debug phase value driven onto the LEDs.
package seq_pkg;

  localparam int PHASE_W = 3;

  localparam logic [PHASE_W-1:0] PHASE_IDLE  = 3'd0;
  localparam logic [PHASE_W-1:0] PHASE_FETCH = 3'd1;
  localparam logic [PHASE_W-1:0] PHASE_EXEC  = 3'd2;
  localparam logic [PHASE_W-1:0] PHASE_MEM   = 3'd3;
  localparam logic [PHASE_W-1:0] PHASE_WB    = 3'd4;
  localparam logic [PHASE_W-1:0] PHASE_FAULT = 3'd7;

  typedef enum logic [PHASE_W-1:0] {
    S_IDLE  = PHASE_IDLE,
    S_FETCH = PHASE_FETCH,
    S_EXEC  = PHASE_EXEC,
    S_MEM   = PHASE_MEM,
    S_WB    = PHASE_WB,
    S_FAULT = PHASE_FAULT
  } seq_state_t;

  // States in which a memory request is outstanding.
  function automatic logic is_mem_state(seq_state_t s);
    return (s == S_FETCH) || (s == S_MEM);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive unanswered memory-request cycles and flags the last allowed one.
// MEM_TIMEOUT=0 removes the counter entirely and never expires.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      logic unused_timer_inputs;
      assign unused_timer_inputs = ^{clk, rst, clear, waiting};
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(MEM_TIMEOUT + 1);
      localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

      logic [CW-1:0] cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (clear) begin
          cnt <= '0;
        end else if (waiting) begin
          cnt <= cnt + 1'b1;
        end
      end

      // Expires in the cycle holding count MEM_TIMEOUT-1 while still unanswered.
      assign expired = waiting && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: IDLE/FETCH/EXEC/MEM/WB/FAULT with a req/ready memory
// handshake; owns PC, instruction register, load-data register and retire counter.
//
// Handshake: mem_req is raised in FETCH/MEM and held until the cycle where
// mem_req && mem_ready; that cycle completes the transfer and mem_rdata is sampled in it.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                MEM_TIMEOUT = 1024,
  parameter int                CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-3:0]   mem_addr,
  input  logic                mem_ready,
  input  logic [31:0]         mem_rdata,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic                is_load,
  input  logic                is_store,
  input  logic                gp_we_dec,
  input  logic [ADDR_W-1:0]   next_pc,
  output logic [ADDR_W-1:0]   pc,
  output logic [31:0]         instr,
  output logic [31:0]         load_data,
  output logic                gp_we,
  output logic [PHASE_W-1:0]  phase,
  output logic [CNT_W-1:0]    retired,
  output logic                timeout_err
);

  seq_state_t state, state_d;

  logic retire;
  logic pc_load;
  logic instr_load;
  logic ld_load;
  logic expired;
  logic completing;
  logic timer_clear;
  logic unused_addr_bits;

  // Request outputs depend on state only, so an asynchronous reset drops them at once.
  assign mem_req    = is_mem_state(state);
  assign mem_we     = (state == S_MEM) && is_store;
  assign mem_addr   = (state == S_MEM) ? data_addr[ADDR_W-1:2] : pc[ADDR_W-1:2];
  assign completing = mem_req && mem_ready;

  assign phase       = state;
  assign timeout_err = (state == S_FAULT);

  assign unused_addr_bits = ^data_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    gp_we      = 1'b0;
    retire     = 1'b0;
    pc_load    = 1'b0;
    instr_load = 1'b0;
    ld_load    = 1'b0;
    case (state)
      S_IDLE: begin
        if (ena) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) begin
          instr_load = 1'b1;
          state_d    = S_EXEC;
        end else if (expired) begin
          state_d = S_FAULT;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          gp_we   = gp_we_dec;
          pc_load = 1'b1;
          retire  = 1'b1;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          pc_load = 1'b1;
          // A load+store decode is treated as a store.
          if (is_store) begin
            retire = 1'b1;
          end else begin
            ld_load = 1'b1;
            state_d = S_WB;
          end
        end else if (expired) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        gp_we  = gp_we_dec;
        retire = 1'b1;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (retire) state_d = ena ? S_FETCH : S_IDLE;
  end

  // Wait counter restarts on every state change and on every completed transfer.
  assign timer_clear = (state_d != state) || completing;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .waiting(mem_req && !mem_ready),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      instr     <= '0;
      load_data <= '0;
      retired   <= '0;
    end else begin
      if (pc_load)    pc        <= next_pc;
      if (instr_load) instr     <= mem_rdata;
      if (ld_load)    load_data <= mem_rdata;
      if (retire)     retired   <= retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: each instruction is expanded into its expected
// per-cycle trace, which a compare process checks against the DUT on every cycle.
module tb_multicycle_sequencer;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 32;
  localparam int TMO    = 8;
  localparam logic [31:0] RST_PC = 32'h0;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                ena = 1'b0;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-3:0]   mem_addr;
  logic                mem_ready = 1'b0;
  logic [31:0]         mem_rdata = '0;
  logic [ADDR_W-1:0]   data_addr = '0;
  logic                is_load = 1'b0;
  logic                is_store = 1'b0;
  logic                gp_we_dec = 1'b0;
  logic [ADDR_W-1:0]   next_pc = '0;
  logic [ADDR_W-1:0]   pc;
  logic [31:0]         instr;
  logic [31:0]         load_data;
  logic                gp_we;
  logic [2:0]          phase;
  logic [CNT_W-1:0]    retired;
  logic                timeout_err;

  multicycle_sequencer #(
    .ADDR_W(ADDR_W), .RESET_PC(RST_PC), .MEM_TIMEOUT(TMO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .data_addr(data_addr), .is_load(is_load), .is_store(is_store),
    .gp_we_dec(gp_we_dec), .next_pc(next_pc),
    .pc(pc), .instr(instr), .load_data(load_data), .gp_we(gp_we),
    .phase(phase), .retired(retired), .timeout_err(timeout_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [2:0]  phase;
    logic        req;
    logic        we;
    logic [29:0] addr;
    logic        gp;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ld;
    logic [31:0] ret;
    logic        terr;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Architectural state as the program should see it.
  logic [31:0] m_pc, m_instr, m_load, m_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("phase", 32'(phase), 32'(e.phase));
      chk("mem_req", 32'(mem_req), 32'(e.req));
      if (e.req) begin
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
      end
      chk("gp_we", 32'(gp_we), 32'(e.gp));
      chk("pc", pc, e.pc);
      chk("instr", instr, e.instr);
      chk("load_data", load_data, e.ld);
      chk("retired", retired, e.ret);
      chk("timeout_err", 32'(timeout_err), 32'(e.terr));
    end
  end

  // ---------------- driver tasks ----------------
  function automatic exp_t mk(input logic [2:0] ph, input logic req, input logic we,
                              input logic [29:0] addr, input logic gp, input logic terr);
    exp_t e;
    e.phase = ph; e.req = req; e.we = we; e.addr = addr; e.gp = gp;
    e.pc = m_pc; e.instr = m_instr; e.ld = m_load; e.ret = m_ret; e.terr = terr;
    return e;
  endfunction

  task automatic step(input exp_t e, input logic rdy, input logic [31:0] rd, input logic en);
    mem_ready = rdy;
    mem_rdata = rd;
    ena       = en;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_instr = '0; m_load = '0; m_ret = '0;
  endtask

  // k cycles parked in IDLE, ena raised only in the last one.
  task automatic idle(input int k);
    for (int j = 0; j < k; j++)
      step(mk(3'd0, 1'b0, 1'b0, '0, 1'b0, 1'b0), 1'($urandom_range(0, 1)), $urandom(),
           (j == k - 1));
  endtask

  // kind: 0=ALU 1=load 2=store 3=load+store. f/m are wait cycles before ready.
  // abort_mem>0 stops after that many unanswered MEM cycles.
  task automatic run_instr(input int kind, input int f, input int m, input logic gpd,
                           input logic exit_ena, input logic [31:0] np,
                           input logic [31:0] da, input logic [31:0] word,
                           input logic [31:0] ld, input int abort_mem);
    logic is_mem, is_st;
    is_mem = (kind != 0);
    is_st  = (kind >= 2);
    is_load   = (kind == 1) || (kind == 3);
    is_store  = is_st;
    gp_we_dec = gpd;
    next_pc   = np;
    data_addr = da;
    for (int j = 0; j <= f; j++)
      step(mk(3'd1, 1'b1, 1'b0, m_pc[31:2], 1'b0, 1'b0), (j == f),
           (j == f) ? word : $urandom(), 1'($urandom_range(0, 1)));
    m_instr = word;
    step(mk(3'd2, 1'b0, 1'b0, '0, (kind == 0) && gpd, 1'b0), 1'($urandom_range(0, 1)),
         $urandom(), is_mem ? 1'($urandom_range(0, 1)) : exit_ena);
    if (!is_mem) begin
      m_pc = np; m_ret++;
    end else begin
      if (abort_mem > 0) begin
        for (int j = 0; j < abort_mem; j++)
          step(mk(3'd3, 1'b1, is_st, da[31:2], 1'b0, 1'b0), 1'b0, $urandom(), 1'b1);
        return;
      end
      for (int j = 0; j <= m; j++)
        step(mk(3'd3, 1'b1, is_st, da[31:2], 1'b0, 1'b0), (j == m),
             (j == m) ? ld : $urandom(),
             (is_st && j == m) ? exit_ena : 1'($urandom_range(0, 1)));
      m_pc = np;
      if (is_st) begin
        m_ret++;
      end else begin
        m_load = ld;
        step(mk(3'd4, 1'b0, 1'b0, '0, gpd, 1'b0), 1'($urandom_range(0, 1)), $urandom(),
             exit_ena);
        m_ret++;
      end
    end
    if (!exit_ena) idle($urandom_range(1, 3));
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] saved_pc;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_gp_we", 32'(gp_we), 32'd0);
    rst = 1'b0;

    // Zero-wait ALU stream, then a slow load and a store to 0x100.
    idle(1);
    for (int i = 0; i < 3; i++)
      run_instr(0, 0, 0, 1'b1, 1'b1, m_pc + 4, '0, 32'h0022_0821, '0, 0);
    chk("alu3_pc", pc, 32'd12);
    chk("alu3_retired", retired, 32'd3);
    run_instr(1, 0, 3, 1'b1, 1'b1, m_pc + 4, 32'h0000_0204, 32'h8c22_0000, 32'hDEADBEEF, 0);
    chk("load_data_literal", load_data, 32'hDEADBEEF);
    run_instr(2, 0, 0, 1'b1, 1'b0, m_pc + 4, 32'h0000_0100, 32'hac22_0000, '0, 0);
    chk("store_retired", retired, 32'd5);
    chk("store_park_phase", 32'(phase), 32'd1);

    // Randomized program: mixed kinds, wait states, branches, ena drops.
    for (int i = 0; i < 60; i++) begin
      int kind;
      logic [31:0] np;
      kind = $urandom_range(0, 3);
      np = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC) : m_pc + 4;
      run_instr(kind, $urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0), np, $urandom(), $urandom(), $urandom(), 0);
    end

    // Unanswered fetch: FAULT after TMO request cycles, sticky until reset.
    saved_pc = m_pc;
    for (int j = 0; j < TMO; j++)
      step(mk(3'd1, 1'b1, 1'b0, m_pc[31:2], 1'b0, 1'b0), 1'b0, $urandom(),
           1'($urandom_range(0, 1)));
    for (int j = 0; j < 5; j++)
      step(mk(3'd7, 1'b0, 1'b0, '0, 1'b0, 1'b1), 1'($urandom_range(0, 1)), $urandom(), 1'b1);
    chk("fault_terr", 32'(timeout_err), 32'd1);
    chk("fault_req", 32'(mem_req), 32'd0);
    chk("fault_pc", pc, saved_pc);
    rst = 1'b1;
    #1;
    chk("fault_clr_terr", 32'(timeout_err), 32'd0);
    chk("fault_clr_phase", 32'(phase), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Reset in the middle of a MEM wait.
    idle(2);
    run_instr(0, 1, 0, 1'b1, 1'b1, 32'h0000_0040, '0, $urandom(), '0, 0);
    run_instr(1, 0, 0, 1'b1, 1'b1, 32'h0000_0044, 32'h0000_0abc, $urandom(), '0, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("midmem_req", 32'(mem_req), 32'd0);
    chk("midmem_we", 32'(mem_we), 32'd0);
    chk("midmem_phase", 32'(phase), 32'd0);
    chk("midmem_pc", pc, RST_PC);
    chk("midmem_retired", retired, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle(2);
    run_instr(0, 0, 0, 1'b1, 1'b0, 32'h0000_0020, '0, $urandom(), '0, 0);
    chk("after_rst_pc", pc, 32'h0000_0020);
    chk("after_rst_retired", retired, 32'd1);

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL queue_drain: got %0d expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
